// File: rtl/pc060ha_comm_ctrl_pkg.sv
// Shared constants and helpers for the PC060HA main<->sound mailbox controller.
package pc060ha_pkg;

  localparam logic [2:0] IDX_STATUS  = 3'd4;
  localparam logic [1:0] SLOT_FLAG_A = 2'd1;
  localparam logic [1:0] SLOT_FLAG_B = 2'd3;

  // Status nibble layout: [1:0] data waiting for me, [3:2] my data still unread.
  localparam int ST_IN_A  = 0;
  localparam int ST_IN_B  = 1;
  localparam int ST_OWN_A = 2;
  localparam int ST_OWN_B = 3;

  localparam int CTRL_BIT = 0;

  function automatic logic [3:0] status_nibble(input logic own_b, input logic own_a,
                                               input logic in_b, input logic in_a);
    logic [3:0] st;
    st           = 4'h0;
    st[ST_OWN_B] = own_b;
    st[ST_OWN_A] = own_a;
    st[ST_IN_B]  = in_b;
    st[ST_IN_A]  = in_a;
    return st;
  endfunction

  function automatic logic [2:0] sat_index(input logic [2:0] v);
    return (v > IDX_STATUS) ? IDX_STATUS : v;
  endfunction

  // Set wins over a clear landing in the same cycle.
  function automatic logic next_flag(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/pc060ha_comm_ctrl_if.sv
// One CPU-side bus of the mailbox: chip select, register select, strobes and data nibbles.
interface pc060ha_comm_ctrl_if;
  logic       CS;
  logic       A0;
  logic       WR;
  logic       RD;
  logic [3:0] DI;
  logic [3:0] DO;

  modport master (output CS, A0, WR, RD, DI, input DO);
  modport slave  (input CS, A0, WR, RD, DI, output DO);
endinterface

// File: rtl/pc060ha_comm_ctrl_port.sv
// Per-side strobe edge detection, index register, and decoded write / read-done pulses.
module pc060ha_port
  import pc060ha_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       cs,
  input  logic       a0,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] idx_di,
  output logic [1:0] slot_s,
  output logic       status_sel_s,
  output logic       comm_wr_s,
  output logic       comm_rd_s
);

  logic             wr_prev_r;
  logic             rd_prev_r;
  logic             rd_a0_r;
  logic [IDX_W-1:0] idx_r;
  logic             wr_lvl_s;
  logic             rd_lvl_s;
  logic             wr_edge_s;
  logic             idx_wr_s;

  assign wr_lvl_s     = cs & wr;
  assign rd_lvl_s     = cs & rd;
  assign wr_edge_s    = wr_lvl_s & ~wr_prev_r & ~hold;
  assign idx_wr_s     = wr_edge_s & ~a0;
  assign comm_wr_s    = wr_edge_s & a0;
  // A0 is remembered from the start of the read, since it may move before the strobe ends.
  assign comm_rd_s    = ~rd_lvl_s & rd_prev_r & rd_a0_r & ~hold;
  assign slot_s       = idx_r[1:0];
  assign status_sel_s = (idx_r == IDX_W'(IDX_STATUS));

  // Strobe history and index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prev_r <= 1'b0;
      rd_prev_r <= 1'b0;
      rd_a0_r   <= 1'b0;
      idx_r     <= '0;
    end else begin
      wr_prev_r <= wr_lvl_s;
      rd_prev_r <= rd_lvl_s;
      if (rd_lvl_s && !rd_prev_r) begin
        rd_a0_r <= a0;
      end
      if (hold) begin
        idx_r <= '0;
      end else if (idx_wr_s) begin
        idx_r <= IDX_W'(sat_index(idx_di));
      end else if ((comm_wr_s || comm_rd_s) && !status_sel_s) begin
        idx_r <= (idx_r == IDX_W'(3)) ? '0 : idx_r + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc060ha_comm_ctrl.sv
// PC060HA mailbox controller: both mailboxes, data-ready flags, and sound-CPU reset/NMI.
module pc060ha_comm_ctrl
  import pc060ha_pkg::*;
#(
  parameter bit RST_ON_BOOT = 1'b1,
  parameter int IDX_W       = 3
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  pc060ha_comm_ctrl_if.slave    m_bus,
  pc060ha_comm_ctrl_if.slave    s_bus,
  output logic                  SND_RESET,
  output logic                  SND_NMI
);

  logic [3:0] ms_r [4];
  logic [3:0] sm_r [4];
  logic       ms_a_r, ms_b_r, sm_a_r, sm_b_r;
  logic       snd_reset_r;
  logic       nmi_en_r;

  logic [1:0] m_slot_s, s_slot_s;
  logic       m_stat_s, s_stat_s;
  logic       m_wr_s, s_wr_s, m_rd_s, s_rd_s;
  logic       m_data_wr_s, s_data_wr_s, m_data_rd_s, s_data_rd_s;

  pc060ha_port #(.IDX_W(IDX_W)) u_mport (
    .clk(MCLK), .rst(RESET), .hold(1'b0),
    .cs(m_bus.CS), .a0(m_bus.A0), .wr(m_bus.WR), .rd(m_bus.RD), .idx_di(m_bus.DI[2:0]),
    .slot_s(m_slot_s), .status_sel_s(m_stat_s), .comm_wr_s(m_wr_s), .comm_rd_s(m_rd_s)
  );

  pc060ha_port #(.IDX_W(IDX_W)) u_sport (
    .clk(MCLK), .rst(RESET), .hold(snd_reset_r),
    .cs(s_bus.CS), .a0(s_bus.A0), .wr(s_bus.WR), .rd(s_bus.RD), .idx_di(s_bus.DI[2:0]),
    .slot_s(s_slot_s), .status_sel_s(s_stat_s), .comm_wr_s(s_wr_s), .comm_rd_s(s_rd_s)
  );

  assign m_data_wr_s = m_wr_s & ~m_stat_s;
  assign s_data_wr_s = s_wr_s & ~s_stat_s;
  assign m_data_rd_s = m_rd_s & ~m_stat_s;
  assign s_data_rd_s = s_rd_s & ~s_stat_s;

  // Mailbox slots, flags and sound-CPU controls.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        ms_r[i] <= 4'h0;
        sm_r[i] <= 4'h0;
      end
      ms_a_r      <= 1'b0;
      ms_b_r      <= 1'b0;
      sm_a_r      <= 1'b0;
      sm_b_r      <= 1'b0;
      snd_reset_r <= RST_ON_BOOT;
      nmi_en_r    <= 1'b0;
    end else begin
      if (m_data_wr_s) begin
        ms_r[m_slot_s] <= m_bus.DI;
      end
      if (s_data_wr_s) begin
        sm_r[s_slot_s] <= s_bus.DI;
      end
      if (m_wr_s && m_stat_s) begin
        snd_reset_r <= m_bus.DI[CTRL_BIT];
      end
      if (snd_reset_r) begin
        nmi_en_r <= 1'b0;
      end else if (s_wr_s && s_stat_s) begin
        nmi_en_r <= s_bus.DI[CTRL_BIT];
      end
      ms_a_r <= next_flag(ms_a_r, m_data_wr_s && (m_slot_s == SLOT_FLAG_A),
                          s_data_rd_s && (s_slot_s == SLOT_FLAG_A));
      ms_b_r <= next_flag(ms_b_r, m_data_wr_s && (m_slot_s == SLOT_FLAG_B),
                          s_data_rd_s && (s_slot_s == SLOT_FLAG_B));
      sm_a_r <= next_flag(sm_a_r, s_data_wr_s && (s_slot_s == SLOT_FLAG_A),
                          m_data_rd_s && (m_slot_s == SLOT_FLAG_A));
      sm_b_r <= next_flag(sm_b_r, s_data_wr_s && (s_slot_s == SLOT_FLAG_B),
                          m_data_rd_s && (m_slot_s == SLOT_FLAG_B));
    end
  end

  // Main-side read mux.
  always_comb begin
    m_bus.DO = 4'h0;
    if (m_bus.CS && m_bus.A0) begin
      m_bus.DO = m_stat_s ? status_nibble(ms_b_r, ms_a_r, sm_b_r, sm_a_r) : sm_r[m_slot_s];
    end else begin
      m_bus.DO = 4'h0;
    end
  end

  // Sound-side read mux; the sound bus is dead while its CPU is held in reset.
  always_comb begin
    s_bus.DO = 4'h0;
    if (s_bus.CS && s_bus.A0 && !snd_reset_r) begin
      s_bus.DO = s_stat_s ? status_nibble(sm_b_r, sm_a_r, ms_b_r, ms_a_r) : ms_r[s_slot_s];
    end else begin
      s_bus.DO = 4'h0;
    end
  end

  assign SND_RESET = snd_reset_r;
  assign SND_NMI   = nmi_en_r & ~snd_reset_r & (ms_a_r | ms_b_r);

endmodule
